bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 139 +++++++++++++
 tb/tb_bus_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master arbiter for a shared memory bus: one outstanding access at a time,
// round-robin on ties, optional abort when the slave does not answer in time.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_wstrb_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_instr_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_wstrb_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_instr_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_wstrb_o,
  output logic [31:0] s_wdata_o,
  output logic        s_instr_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          lst_q, lst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          instr_q, instr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          pick_m1;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      lst_q   <= 1'b1;  // master 0 wins the first tie after reset
      cnt_q   <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      instr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      lst_q   <= lst_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    lst_d   = lst_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    pick_m1 = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          pick_m1 = (m0_valid_i && m1_valid_i) ? ~lst_q : m1_valid_i;
          gnt_d   = pick_m1;
          addr_d  = pick_m1 ? m1_addr_i  : m0_addr_i;
          wstrb_d = pick_m1 ? m1_wstrb_i : m0_wstrb_i;
          wdata_d = pick_m1 ? m1_wdata_i : m0_wdata_i;
          instr_d = pick_m1 ? m1_instr_i : m0_instr_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // a slave answer in the abort cycle still completes normally
        if (s_ready_i) begin
          rdata_d = s_rdata_i;
          err_d   = 1'b0;
          lst_d   = gnt_q;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          lst_d   = gnt_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s_valid_o = (state_q == BUSY);
  assign s_addr_o  = addr_q;
  assign s_wstrb_o = wstrb_q;
  assign s_wdata_o = wdata_q;
  assign s_instr_o = instr_q;

  assign m0_ready_o = (state_q == RESP) && !gnt_q;
  assign m1_ready_o = (state_q == RESP) &&  gnt_q;
  assign m0_rdata_o = m0_ready_o ? rdata_q : '0;
  assign m1_rdata_o = m1_ready_o ? rdata_q : '0;
  assign m0_err_o   = m0_ready_o && err_q;
  assign m1_err_o   = m1_ready_o && err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected master responses are queued as
// requests are issued and popped when a ready pulse appears.
module tb_bus_arbiter;

  localparam logic [31:0] RD_XOR = 32'h5A5A_0F0F;

  logic        clk_i, rst_ni;
  logic        m0_valid_i, m1_valid_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic [3:0]  m0_wstrb_i, m1_wstrb_i;
  logic        m0_instr_i, m1_instr_i;
  logic        m0_ready_o, m1_ready_o, m0_err_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_valid_o, s_instr_o, s_ready_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_wstrb_o;

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wstrb_i(m0_wstrb_i),
    .m0_wdata_i(m0_wdata_i), .m0_instr_i(m0_instr_i), .m0_ready_o(m0_ready_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wstrb_i(m1_wstrb_i),
    .m1_wdata_i(m1_wdata_i), .m1_instr_i(m1_instr_i), .m1_ready_o(m1_ready_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wstrb_o(s_wstrb_o),
    .s_wdata_o(s_wdata_o), .s_instr_o(s_instr_o),
    .s_ready_i(s_ready_i), .s_rdata_i(s_rdata_i)
  );

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   resp_cnt = 0;

  // slave behaviour knobs
  bit          slv_hang = 1'b0;
  bit          slv_fixed = 1'b0;
  int          slv_delay = 0;
  logic [31:0] slv_data = '0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d responses", resp_cnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic push_exp(input int m, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.m = m;
    e.rdata = rdata;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // slave: answers after slv_delay BUSY cycles, never when hung
  initial begin
    int slv_wait;
    slv_wait = 0;
    s_ready_i = 1'b0;
    s_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (s_valid_o && !slv_hang) begin
        if (slv_wait >= slv_delay) begin
          s_ready_i = 1'b1;
          s_rdata_i = slv_fixed ? slv_data : (s_addr_o ^ RD_XOR);
        end else begin
          s_ready_i = 1'b0;
        end
        slv_wait++;
      end else begin
        s_ready_i = 1'b0;
        s_rdata_i = '0;
        slv_wait = 0;
      end
    end
  end

  // response monitor
  initial begin
    exp_t e;
    int   obs_m;
    forever begin
      @(negedge clk_i);
      if (m0_ready_o || m1_ready_o) begin
        chk("rdy_onehot", {31'b0, m0_ready_o & m1_ready_o}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_rdy", {30'b0, m1_ready_o, m0_ready_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          obs_m = m1_ready_o ? 1 : 0;
          chk("rsp_master", obs_m, e.m);
          chk("rsp_rdata", obs_m ? m1_rdata_o : m0_rdata_o, e.rdata);
          chk("rsp_err", {31'b0, obs_m ? m1_err_o : m0_err_o}, {31'b0, e.err});
          chk("other_rdata", obs_m ? m0_rdata_o : m1_rdata_o, 32'd0);
          chk("other_err", {31'b0, obs_m ? m0_err_o : m1_err_o}, 32'd0);
        end
        resp_cnt++;
      end else begin
        chk("quiet_outputs", m0_rdata_o | m1_rdata_o | {30'b0, m0_err_o, m1_err_o}, 32'd0);
      end
    end
  end

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && !s_valid_o; i++) begin
      @(negedge clk_i);
      #1;
    end
    chk("busy_wait", {31'b0, s_valid_o}, 32'd1);
  endtask

  task automatic run_until_resp(input int tgt, input int budget, input bit chk_f,
                                input logic [31:0] ea, input logic [31:0] ew,
                                input logic [3:0] es, output int vcyc);
    vcyc = 0;
    for (int i = 0; i < budget && resp_cnt < tgt; i++) begin
      @(negedge clk_i);
      #1;
      if (s_valid_o) begin
        vcyc++;
        if (chk_f) begin
          chk("busy_addr", s_addr_o, ea);
          chk("busy_wdata", s_wdata_o, ew);
          chk("busy_wstrb", {28'b0, s_wstrb_o}, {28'b0, es});
        end
      end
    end
    chk("resp_wait", {31'b0, resp_cnt >= tgt}, 32'd1);
  endtask

  initial begin
    int vc;
    rst_ni = 1'b0;
    m0_valid_i = 0; m0_addr_i = '0; m0_wstrb_i = '0; m0_wdata_i = '0; m0_instr_i = 0;
    m1_valid_i = 0; m1_addr_i = '0; m1_wstrb_i = '0; m1_wdata_i = '0; m1_instr_i = 0;

    repeat (3) @(negedge clk_i);
    chk("rst_svalid", {31'b0, s_valid_o}, 32'd0);
    chk("rst_saddr", s_addr_o, 32'd0);
    chk("rst_swdata", s_wdata_o, 32'd0);
    chk("rst_sctl", {27'b0, s_wstrb_o, s_instr_o}, 32'd0);
    chk("rst_ready", {30'b0, m1_ready_o, m0_ready_o}, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // tie after reset, then continuous requests alternate
    @(posedge clk_i); #1;
    m0_addr_i = 32'h0000_1000; m0_instr_i = 1'b1; m0_valid_i = 1'b1;
    m1_addr_i = 32'h0000_2000; m1_instr_i = 1'b0; m1_valid_i = 1'b1;
    push_exp(0, 32'h0000_1000 ^ RD_XOR, 1'b0);
    push_exp(1, 32'h0000_2000 ^ RD_XOR, 1'b0);
    push_exp(0, 32'h0000_1000 ^ RD_XOR, 1'b0);
    push_exp(1, 32'h0000_2000 ^ RD_XOR, 1'b0);
    run_until_resp(resp_cnt + 4, 40, 1'b0, '0, '0, '0, vc);
    m0_valid_i = 1'b0; m1_valid_i = 1'b0; m0_instr_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // single read, slave answers in the same cycle the abort would fire
    slv_fixed = 1'b1; slv_data = 32'hDEAD_BEEF; slv_delay = 3;
    @(posedge clk_i); #1;
    m0_addr_i = 32'h0000_0100; m0_wstrb_i = 4'h0; m0_valid_i = 1'b1;
    push_exp(0, 32'hDEAD_BEEF, 1'b0);
    wait_busy(10);
    chk("rd_saddr", s_addr_o, 32'h0000_0100);
    chk("rd_sctl", {27'b0, s_wstrb_o, s_instr_o}, 32'd0);
    m0_valid_i = 1'b0;
    m0_addr_i = 32'h0000_0999;
    @(negedge clk_i); #1;
    chk("stable_addr", s_addr_o, 32'h0000_0100);
    run_until_resp(resp_cnt + 1, 20, 1'b1, 32'h0000_0100, 32'd0, 4'h0, vc);
    repeat (2) @(negedge clk_i);

    // write from master 1
    slv_data = 32'hCAFE_0001; slv_delay = 2;
    @(posedge clk_i); #1;
    m1_addr_i = 32'h0000_0040; m1_wdata_i = 32'h1234_5678; m1_wstrb_i = 4'hF; m1_valid_i = 1'b1;
    push_exp(1, 32'hCAFE_0001, 1'b0);
    run_until_resp(resp_cnt + 1, 20, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, vc);
    m1_valid_i = 1'b0;
    chk("wr_busy_cycles", vc, 3);
    repeat (2) @(negedge clk_i);

    // timeout abort
    slv_hang = 1'b1;
    @(posedge clk_i); #1;
    m0_addr_i = 32'h0000_0200; m0_valid_i = 1'b1;
    push_exp(0, 32'd0, 1'b1);
    run_until_resp(resp_cnt + 1, 30, 1'b1, 32'h0000_0200, 32'd0, 4'h0, vc);
    m0_valid_i = 1'b0;
    chk("to_svalid_cycles", vc, 4);
    repeat (2) @(negedge clk_i);

    // reset in the middle of an access
    @(posedge clk_i); #1;
    m1_addr_i = 32'h0000_0300; m1_wstrb_i = 4'h0; m1_valid_i = 1'b1;
    wait_busy(10);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_async_svalid", {31'b0, s_valid_o}, 32'd0);
    chk("rst_async_saddr", s_addr_o, 32'd0);
    m1_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    slv_hang = 1'b0; slv_fixed = 1'b0; slv_delay = 0;
    @(posedge clk_i); #1 rst_ni = 1'b1;

    @(posedge clk_i); #1;
    m0_addr_i = 32'h0000_4000; m0_valid_i = 1'b1;
    m1_addr_i = 32'h0000_8000; m1_valid_i = 1'b1;
    push_exp(0, 32'h0000_4000 ^ RD_XOR, 1'b0);
    push_exp(1, 32'h0000_8000 ^ RD_XOR, 1'b0);
    run_until_resp(resp_cnt + 2, 20, 1'b0, '0, '0, '0, vc);
    m0_valid_i = 1'b0; m1_valid_i = 1'b0;

    repeat (4) @(negedge clk_i);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
